// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage of the 5-stage pipeline.
// Runs a req/ack data-memory handshake for loads and stores, and stalls the
// upstream stages while an access is outstanding. It also holds the MEM/WB
// pipeline register. Non-memory instructions pass through in one cycle.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access that
// is never acknowledged is aborted after TIMEOUT_CYCLES busy cycles.
module mem_stage_ctrl #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [4:0]        rd_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rdata_q;
  logic              access;
  logic              timed_out;

  // The wait counter must be able to hold TIMEOUT_CYCLES.
  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("mem_stage_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  assign access = MemRead_i | MemWrite_i;

  // The request follows the state register directly. An asynchronous reset
  // out of BUSY therefore drops the request immediately.
  assign mem_req_o = (state == BUSY);

  // Freeze upstream from the cycle the access is seen until the ack arrives.
  // DONE releases the stall, so EX/MEM advances on the same edge at which the
  // result is written into MEM/WB.
  assign stall_o = rst_i & (((state == IDLE) & access) | (state == BUSY));

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign err_o     = err_q;
  assign timed_out = (state == DONE) & err_q;
`else
  assign err_o     = 1'b0;
  assign timed_out = 1'b0;
`endif

  // Access FSM: latch the request in IDLE, wait for the ack in BUSY,
  // then present the result for one cycle in DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state       <= BUSY;
            // A store takes priority when both read and write are flagged.
            mem_we_o    <= MemWrite_i;
            // The byte offset is dropped; misalignment does not trap.
            mem_addr_o  <= {addr_i[DATA_W-1:2], 2'b00};
            mem_wdata_o <= wdata_i;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state   <= DONE;
            rdata_q <= mem_we_o ? '0 : mem_rdata_i;
          end
`ifdef MEM_TIMEOUT_EN
          // An ack in the final allowed cycle still completes normally.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            rdata_q <= DATA_W'(32'hDEADBEEF);
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef MEM_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- MEM/WB boundary ----
  // The MEM/WB register loads on every edge. A stall inserts a bubble.
  // Otherwise it captures the EX/MEM fields, plus the load data when DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      MemToReg_o <= 1'b0;
      rd_o       <= '0;
      alu_o      <= '0;
      rdata_o    <= '0;
    end else if (stall_o) begin
      RegWrite_o <= 1'b0;
      MemToReg_o <= 1'b0;
      rd_o       <= '0;
      alu_o      <= '0;
      rdata_o    <= '0;
    end else begin
      // An aborted access must not update the register file.
      RegWrite_o <= RegWrite_i & ~timed_out;
      MemToReg_o <= MemToReg_i;
      rd_o       <= rd_i;
      alu_o      <= addr_i;
      rdata_o    <= (state == DONE) ? rdata_q : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl. It applies a table of directed instructions,
// a set of hand-written reset and timeout sequences, and random instructions
// whose expected results come from a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int DATA_W = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic              clk_i, rst_i;
  logic              MemToReg_i, RegWrite_i, MemRead_i, MemWrite_i;
  logic [DATA_W-1:0] addr_i, wdata_i;
  logic [4:0]        rd_i;
  logic              mem_req_o, mem_we_o;
  logic [DATA_W-1:0] mem_addr_o, mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o, RegWrite_o, MemToReg_o;
  logic [DATA_W-1:0] rdata_o, alu_o;
  logic [4:0]        rd_o;
  logic              err_o;

  mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemToReg_i(MemToReg_i), .RegWrite_i(RegWrite_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .rdata_o(rdata_o), .alu_o(alu_o), .rd_o(rd_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rw, mt, mr, mw;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    int          delay;      // ack arrives in BUSY cycle delay+1
    logic [31:0] rdata;
    int          exp_stall;  // number of cycles with stall_o high
    logic [31:0] exp_maddr;
    logic        exp_we, exp_rw, exp_mt;
    logic [4:0]  exp_rd;
    logic [31:0] exp_alu, exp_rdata;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic rw, mt, mr, mw, input logic [31:0] addr, wdata, input logic [4:0] rd,
    input int delay, input logic [31:0] rdata, input int exp_stall,
    input logic [31:0] exp_maddr, input logic exp_we, exp_rw, exp_mt,
    input logic [4:0] exp_rd, input logic [31:0] exp_alu, exp_rdata);
    vec_t v;
    v.rw = rw; v.mt = mt; v.mr = mr; v.mw = mw; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.delay = delay; v.rdata = rdata; v.exp_stall = exp_stall;
    v.exp_maddr = exp_maddr; v.exp_we = exp_we; v.exp_rw = exp_rw; v.exp_mt = exp_mt;
    v.exp_rd = exp_rd; v.exp_alu = exp_alu; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Transaction-level reference. A memory op stalls for the cycle it is seen
  // plus every busy cycle up to and including the ack. A non-memory op never
  // stalls. Only a pure load returns data.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit is_mem = v.mr || v.mw;
    r.exp_stall = is_mem ? (1 + v.delay + 1) : 0;
    r.exp_maddr = v.addr & 32'hFFFF_FFFC;
    r.exp_we    = v.mw;
    r.exp_rw    = v.rw;
    r.exp_mt    = v.mt;
    r.exp_rd    = v.rd;
    r.exp_alu   = v.addr;
    r.exp_rdata = (v.mr && !v.mw) ? v.rdata : 32'h0;
    return r;
  endfunction

  task automatic drive_idle();
    MemToReg_i = 0; RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0;
    addr_i = '0; wdata_i = '0; rd_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  // Called about 1 time unit after a rising edge with the FSM in IDLE.
  // Returns with the FSM back in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int    stalls = 0;
    string t = $sformatf("v%0d", idx);
    MemToReg_i = v.mt; RegWrite_i = v.rw; MemRead_i = v.mr; MemWrite_i = v.mw;
    addr_i = v.addr; wdata_i = v.wdata; rd_i = v.rd;
    if (v.mr || v.mw) begin
      mem_ack_i = 0;
      @(negedge clk_i);
      if (stall_o) stalls++;
      chk({t, "_idle_req"}, mem_req_o, 0);
      for (int i = 0; i <= v.delay; i++) begin
        @(posedge clk_i); #1;
        chk({t, "_req"},    mem_req_o, 1);
        chk({t, "_we"},     mem_we_o, v.exp_we);
        chk({t, "_maddr"},  mem_addr_o, v.exp_maddr);
        chk({t, "_mwdata"}, mem_wdata_o, v.wdata);
        chk({t, "_bubble_rw"}, RegWrite_o, 0);
        chk({t, "_bubble_rd"}, rd_o, 0);
        mem_ack_i   = (i == v.delay);
        mem_rdata_i = (i == v.delay) ? v.rdata : $urandom;
        @(negedge clk_i);
        if (stall_o) stalls++;
      end
      @(posedge clk_i); #1;
      // A stray ack while in DONE must be ignored.
      mem_ack_i   = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      chk({t, "_done_req"}, mem_req_o, 0);
      chk({t, "_done_err"}, err_o, 0);
      chk({t, "_done_rw"},  RegWrite_o, 0);
      @(negedge clk_i);
      if (stall_o) stalls++;
    end else begin
      // A stray ack while in IDLE must be ignored.
      mem_ack_i   = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      @(negedge clk_i);
      if (stall_o) stalls++;
    end
    chk({t, "_stall_cycles"}, stalls, v.exp_stall);
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    chk({t, "_wb_req"},   mem_req_o, 0);
    chk({t, "_wb_rw"},    RegWrite_o, v.exp_rw);
    chk({t, "_wb_mt"},    MemToReg_o, v.exp_mt);
    chk({t, "_wb_rd"},    rd_o, v.exp_rd);
    chk({t, "_wb_alu"},   alu_o, v.exp_alu);
    chk({t, "_wb_rdata"}, rdata_o, v.exp_rdata);
  endtask

  vec_t table_v[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 rw mt mr mw addr           wdata          rd  dly rdata          stall maddr          we rw mt rd  alu            rdata
    table_v[0] = mkv(1, 0, 0, 0, 32'h0000_1234, 32'h0,         5,  0, 32'h0,         0, 32'h0000_1234, 0, 1, 0, 5,  32'h0000_1234, 32'h0);
    table_v[1] = mkv(1, 1, 1, 0, 32'h0000_0103, 32'h0,         3,  3, 32'hCAFE_F00D, 5, 32'h0000_0100, 0, 1, 1, 3,  32'h0000_0103, 32'hCAFE_F00D);
    table_v[2] = mkv(0, 0, 0, 1, 32'h0000_2000, 32'hA5A5_A5A5, 0,  0, 32'h1111_2222, 2, 32'h0000_2000, 1, 0, 0, 0,  32'h0000_2000, 32'h0);
    table_v[3] = mkv(1, 1, 1, 0, 32'hFFFF_FFFE, 32'h0,         31, 0, 32'h0BAD_F00D, 2, 32'hFFFF_FFFC, 0, 1, 1, 31, 32'hFFFF_FFFE, 32'h0BAD_F00D);
    table_v[4] = mkv(0, 0, 1, 1, 32'h0000_0041, 32'h1234_5678, 0,  1, 32'h7777_7777, 3, 32'h0000_0040, 1, 0, 0, 0,  32'h0000_0041, 32'h0);
    table_v[5] = mkv(0, 1, 0, 0, 32'hDEAD_0001, 32'h5,         9,  0, 32'h0,         0, 32'h0,         0, 0, 1, 9,  32'hDEAD_0001, 32'h0);
    table_v[6] = mkv(1, 1, 1, 0, 32'h0000_0008, 32'h0,         17, 2, 32'hFFFF_FFFF, 4, 32'h0000_0008, 0, 1, 1, 17, 32'h0000_0008, 32'hFFFF_FFFF);

    // Reset with an ack pending: everything stays at zero.
    drive_idle();
    rst_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h5555_AAAA;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req",   mem_req_o, 0);
    chk("rst_we",    mem_we_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rw",    RegWrite_o, 0);
    chk("rst_mt",    MemToReg_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_alu",   alu_o, 0);
    chk("rst_rd",    rd_o, 0);
    chk("rst_err",   err_o, 0);
    @(negedge clk_i);
    rst_i = 1; mem_ack_i = 0;
    @(posedge clk_i); #1;
    chk("post_rst_req", mem_req_o, 0);

    for (int i = 0; i < 7; i++) run_vec(table_v[i], i);

    // Reset in the middle of BUSY aborts the access and writes nothing back.
    MemRead_i = 1; RegWrite_i = 1; MemToReg_i = 1; rd_i = 4; addr_i = 32'h50;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("midrst_req_before", mem_req_o, 1);
    #2 rst_i = 0;
    #1;
    chk("midrst_req_drop", mem_req_o, 0);
    chk("midrst_rw",       RegWrite_o, 0);
    drive_idle();
    @(negedge clk_i);
    rst_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("midrst_after%0d_req", i), mem_req_o, 0);
      chk($sformatf("midrst_after%0d_rw", i),  RegWrite_o, 0);
    end

`ifdef MEM_TIMEOUT_EN
    // An access with no ack is aborted after TO busy cycles.
    MemRead_i = 1; RegWrite_i = 1; MemToReg_i = 1; rd_i = 7; addr_i = 32'h300;
    for (int i = 0; i < TO; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("to_busy%0d_req", i), mem_req_o, 1);
    end
    @(posedge clk_i); #1;
    chk("to_done_req", mem_req_o, 0);
    chk("to_done_err", err_o, 1);
    @(posedge clk_i); #1;
    chk("to_wb_err",   err_o, 0);
    chk("to_wb_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("to_wb_rw",    RegWrite_o, 0);
    chk("to_wb_rd",    rd_o, 7);
    chk("to_wb_mt",    MemToReg_o, 1);
`else
    // Without the timeout feature, BUSY waits for as long as it takes.
    begin
      int req_cycles = 0;
      int err_seen   = 0;
      MemRead_i = 1; RegWrite_i = 1; MemToReg_i = 1; rd_i = 7; addr_i = 32'h300;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk_i); #1;
        if (mem_req_o) req_cycles++;
        if (err_o) err_seen++;
      end
      chk("long_req_cycles", req_cycles, 80);
      chk("long_err_seen",   err_seen, 0);
      mem_ack_i = 1; mem_rdata_i = 32'h0F0F_1234;
      @(posedge clk_i); #1;
      mem_ack_i = 0;
      chk("long_done_req", mem_req_o, 0);
      @(posedge clk_i); #1;
      chk("long_wb_rdata", rdata_o, 32'h0F0F_1234);
      chk("long_wb_rw",    RegWrite_o, 1);
    end
`endif

    // Random instructions checked against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int   kind = $urandom_range(0, 9);
      v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rw = 1'($urandom_range(0, 1));
      v.mt = 1'($urandom_range(0, 1));
      if (kind >= 4) begin
        case ($urandom_range(0, 2))
          0: begin v.mr = 1; v.mw = 0; end
          1: begin v.mr = 0; v.mw = 1; end
          default: begin v.mr = 1; v.mw = 1; end
        endcase
      end
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.rd    = 5'($urandom_range(0, 31));
      v.delay = $urandom_range(0, 3);
      v.rdata = $urandom;
      run_vec(model(v), 100 + i);
    end

    drive_idle();
    @(posedge clk_i); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
